// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pins plus RAM-side rx/tx handshake for the SPI slave front end
interface spi_slave_if_if #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  tx_valid;

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave that deframes 10-bit commands and serialises RAM read data on MISO
module spi_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 10,
    parameter int DATA_BITS   = 8
) (
    input logic           clk,
    input logic           rst,
    spi_slave_if_if.slave bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_n_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic                   r_rd_addr_done;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx_loaded;
    logic [TW-1:0]          r_tx_cnt;
    logic                   r_wait_tx;

    logic                   w_sclk;
    logic                   w_ss_n;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_last;
    logic [FRAME_BITS-1:0]  w_shift_next;

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_n       = r_ss_n_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk & ~r_sclk_d;
    assign w_sclk_fall  = ~w_sclk & r_sclk_d;
    assign w_last       = r_cnt == CW'(FRAME_BITS - 1);
    assign w_shift_next = {r_shift[FRAME_BITS-2:0], w_mosi};

    assign bus.miso     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

    // Pin synchronisers; ss_n resets inactive so a held-low select is seen as a fresh falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ss_n_sync <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_ss_n_sync <= {r_ss_n_sync[SYNC_STAGES-2:0], bus.ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_d    <= w_sclk;
        end
    end

    // Frame FSM: receive shift, rx pulse, read-data latch and MISO serialiser; deselect aborts first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_miso         <= 1'b0;
            r_rd_addr_done <= 1'b0;
            r_tx_shift     <= '0;
            r_tx_loaded    <= 1'b0;
            r_tx_cnt       <= '0;
            r_wait_tx      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state != IDLE && w_ss_n) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_miso      <= 1'b0;
                r_tx_loaded <= 1'b0;
                r_wait_tx   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso <= 1'b0;
                        r_cnt  <= '0;
                        if (!w_ss_n)
                            r_state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= CW'(1);
                            r_state <= !w_mosi ? WRITE : r_rd_addr_done ? READ_DATA : READ_ADD;
                        end
                    end
                    default: begin
                        if (w_sclk_rise && r_cnt != CW'(FRAME_BITS)) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + CW'(1);
                            if (w_last) begin
                                r_rx_data  <= w_shift_next;
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD)
                                    r_rd_addr_done <= 1'b1;
                                if (r_state == READ_DATA)
                                    r_wait_tx <= 1'b1;
                            end
                        end
                        if (r_wait_tx && bus.tx_valid) begin
                            r_tx_shift  <= bus.tx_data;
                            r_tx_loaded <= 1'b1;
                            r_tx_cnt    <= '0;
                            r_wait_tx   <= 1'b0;
                        end
                        if (r_tx_loaded && w_sclk_fall) begin
                            r_miso     <= r_tx_shift[DATA_BITS-1];
                            r_tx_shift <= {r_tx_shift[DATA_BITS-2:0], 1'b0};
                            r_tx_cnt   <= r_tx_cnt + TW'(1);
                            if (r_tx_cnt == TW'(DATA_BITS - 1)) begin
                                r_tx_loaded    <= 1'b0;
                                r_rd_addr_done <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed scenarios for the SPI slave front end with hand-computed expectations
module tb_spi_slave_if;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_rx = 0;
    int         miso_hi = 0;
    logic [9:0] rx_cap = '0;
    logic       arm = 1'b0;
    logic       tx_pending = 1'b0;
    logic       stray = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if_if #(.FRAME_BITS(10), .DATA_BITS(8)) bus ();

    spi_slave_if #(.SYNC_STAGES(2), .FRAME_BITS(10), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // One clock step: sample just after the edge, log rx pulses, answer an armed read one cycle later
    task automatic step();
        @(posedge clk);
        #1;
        bus.tx_valid = tx_pending | stray;
        tx_pending = 1'b0;
        if (bus.rx_valid === 1'b1) begin
            n_rx++;
            rx_cap = bus.rx_data;
            if (arm) begin
                tx_pending = 1'b1;
                arm = 1'b0;
            end
        end
        if (bus.miso === 1'b1)
            miso_hi++;
    endtask

    task automatic pulse(input logic b, output logic m);
        bus.mosi = b;
        step();
        step();
        bus.sclk = 1'b1;
        repeat (H) step();
        bus.sclk = 1'b0;
        repeat (H) step();
        m = bus.miso;
    endtask

    task automatic frame(input logic [9:0] f, input int nbits);
        logic m;
        for (int i = 9; i > 9 - nbits; i--)
            pulse(f[i], m);
    endtask

    task automatic open_ss();
        bus.ss_n = 1'b0;
        repeat (4) step();
    endtask

    task automatic close_ss();
        bus.ss_n = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ss_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.sclk = ~bus.sclk;
            step();
            n_checks++;
            if (bus.miso !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_miso cycle %0d: got %b want 0", c, bus.miso);
            end
            n_checks++;
            if (bus.rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rx_valid cycle %0d: got %b want 0", c, bus.rx_valid);
            end
            n_checks++;
            if (bus.rx_data !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_rx_data cycle %0d: got %h want 000", c, bus.rx_data);
            end
        end
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_write_addr();
        logic m;
        n_rx = 0;
        miso_hi = 0;
        open_ss();
        frame(10'h055, 10);
        n_checks++;
        if (n_rx !== 1 || rx_cap !== 10'h055) begin
            n_fail++;
            $display("FAIL write_addr: got %0d pulses data %h want 1 pulse data 055", n_rx, rx_cap);
        end
        pulse(1'b1, m);
        pulse(1'b0, m);
        n_checks++;
        if (n_rx !== 1) begin
            n_fail++;
            $display("FAIL counter_saturate: got %0d pulses want 1", n_rx);
        end
        close_ss();
        n_checks++;
        if (miso_hi !== 0 || bus.miso !== 1'b0) begin
            n_fail++;
            $display("FAIL write_addr_miso: got %0d high cycles want 0", miso_hi);
        end
    endtask

    task automatic test_write_data();
        n_rx = 0;
        open_ss();
        frame(10'h1AA, 10);
        n_checks++;
        if (n_rx !== 1 || rx_cap !== 10'h1AA) begin
            n_fail++;
            $display("FAIL write_data: got %0d pulses data %h want 1 pulse data 1aa", n_rx, rx_cap);
        end
        close_ss();
    endtask

    task automatic test_read();
        logic       m;
        logic [7:0] exp_bits;
        exp_bits = 8'hC3;
        bus.tx_data = 8'hC3;
        n_rx = 0;
        open_ss();
        frame(10'h207, 10);
        n_checks++;
        if (n_rx !== 1 || rx_cap !== 10'h207) begin
            n_fail++;
            $display("FAIL read_addr: got %0d pulses data %h want 1 pulse data 207", n_rx, rx_cap);
        end
        close_ss();
        n_rx = 0;
        open_ss();
        arm = 1'b1;
        frame(10'h300, 9);
        pulse(1'b0, m);
        n_checks++;
        if (n_rx !== 1 || rx_cap !== 10'h300) begin
            n_fail++;
            $display("FAIL read_cmd: got %0d pulses data %h want 1 pulse data 300", n_rx, rx_cap);
        end
        for (int b = 7; b >= 0; b--) begin
            if (b != 7)
                pulse(1'b0, m);
            n_checks++;
            if (m !== exp_bits[b]) begin
                n_fail++;
                $display("FAIL read_miso bit %0d: got %b want %b", b, m, exp_bits[b]);
            end
        end
        pulse(1'b0, m);
        n_checks++;
        if (m !== 1'b1) begin
            n_fail++;
            $display("FAIL read_miso_hold: got %b want 1", m);
        end
        close_ss();
        n_checks++;
        if (bus.miso !== 1'b0) begin
            n_fail++;
            $display("FAIL read_miso_idle: got %b want 0", bus.miso);
        end
        miso_hi = 0;
        open_ss();
        arm = 1'b1;
        frame(10'h300, 10);
        for (int b = 0; b < 8; b++)
            pulse(1'b0, m);
        close_ss();
        n_checks++;
        if (miso_hi !== 0) begin
            n_fail++;
            $display("FAIL rd_addr_cleared: got %0d miso high cycles want 0", miso_hi);
        end
        arm = 1'b0;
    endtask

    task automatic test_abort();
        n_rx = 0;
        open_ss();
        frame(10'h0F0, 6);
        close_ss();
        n_checks++;
        if (n_rx !== 0) begin
            n_fail++;
            $display("FAIL abort_partial: got %0d pulses want 0", n_rx);
        end
        open_ss();
        frame(10'h0F0, 10);
        close_ss();
        n_checks++;
        if (n_rx !== 1 || rx_cap !== 10'h0F0) begin
            n_fail++;
            $display("FAIL abort_recover: got %0d pulses data %h want 1 pulse data 0f0", n_rx, rx_cap);
        end
    endtask

    task automatic test_abort_last_rise();
        n_rx = 0;
        open_ss();
        frame(10'h155, 9);
        bus.mosi = 1'b1;
        step();
        step();
        bus.sclk = 1'b1;
        bus.ss_n = 1'b1;
        repeat (H) step();
        bus.sclk = 1'b0;
        repeat (6) step();
        n_checks++;
        if (n_rx !== 0) begin
            n_fail++;
            $display("FAIL abort_tenth_rise: got %0d pulses want 0", n_rx);
        end
    endtask

    task automatic test_stray_tx();
        logic m;
        stray = 1'b1;
        bus.tx_data = 8'hFF;
        n_rx = 0;
        miso_hi = 0;
        open_ss();
        frame(10'h0AA, 10);
        for (int b = 0; b < 8; b++)
            pulse(1'b0, m);
        close_ss();
        stray = 1'b0;
        step();
        n_checks++;
        if (miso_hi !== 0 || n_rx !== 1 || rx_cap !== 10'h0AA) begin
            n_fail++;
            $display("FAIL stray_tx: got %0d miso high, %0d pulses, data %h want 0, 1, 0aa", miso_hi, n_rx, rx_cap);
        end
    endtask

    task automatic test_rst_midframe();
        n_rx = 0;
        open_ss();
        frame(10'h3FF, 5);
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.miso !== 1'b0 || bus.rx_data !== 10'h000) begin
            n_fail++;
            $display("FAIL rst_midframe: got valid %b miso %b data %h want 0 0 000", bus.rx_valid, bus.miso, bus.rx_data);
        end
        step();
        rst = 1'b0;
        repeat (4) step();
        frame(10'h3FF, 5);
        close_ss();
        n_checks++;
        if (n_rx !== 0) begin
            n_fail++;
            $display("FAIL rst_midframe_pulse: got %0d pulses want 0", n_rx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_abort_last_rise();
        test_stray_tx();
        test_rst_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI mode-0 slave front end sitting directly upstream of the single-port RAM block.
- Deserialises 10-bit command/data frames from MOSI and presents each as `rx_data` with a one-cycle `rx_valid` pulse.
- For read-data frames, captures the RAM's 8-bit `tx_data` on `tx_valid` and serialises it MSB-first on MISO.
- All logic runs on the system clock `clk`; SPI pins are synchronised and edge-detected, never used as clocks.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on `sclk`, `ss_n` and `mosi` (minimum 2).
- FRAME_BITS, 10, bits per received frame; must equal the RAM command width.
- DATA_BITS, 8, bits shifted out on MISO per read-data frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- sclk  input  1  SPI clock from master, asynchronous; half-period ≥ 4 `clk` cycles.
- ss_n  input  1  SPI slave select, active-low, asynchronous.
- mosi  input  1  SPI master-out data, asynchronous.
- miso  output  1  SPI master-in data, registered.
- rx_data  output  FRAME_BITS  received frame, MSB first on wire; [9:8] = command.
- rx_valid  output  1  one-cycle pulse, `rx_data` valid.
- tx_data  input  DATA_BITS  read data from RAM.
- tx_valid  input  1  `tx_data` valid, sampled only while awaiting read data.

Behaviour:
- Reset (`rst`=1 at a `clk` edge): state=IDLE, `miso`=0, `rx_data`=0, `rx_valid`=0, bit counter=0, `rd_addr_done`=0, tx shift register=0, `tx_loaded`=0.
- Synchronise `sclk`/`ss_n`/`mosi` through SYNC_STAGES flops.
- Edge detection:
  - `sclk_rise`/`sclk_fall` = synced value vs one extra registered copy.
  - `mosi` is sampled from its synced copy on `sclk_rise`.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - `miso`=0, counter=0.
  - Synced `ss_n`=0 -> CHK_CMD.
- CHK_CMD, first `sclk_rise`:
  - Sampled bit shifted in as frame bit 9; counter=1.
  - Bit=0 -> WRITE.
  - Bit=1 and `rd_addr_done`=0 -> READ_ADD.
  - Bit=1 and `rd_addr_done`=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA:
  - Each `sclk_rise` shifts `mosi` in MSB-first and increments the counter.
  - On the rise that makes the counter reach FRAME_BITS: next `clk` `rx_data`=shift value and `rx_valid`=1 for exactly one cycle.
  - Latency: `rx_valid` asserts 1 `clk` after the detected 10th rise.
- READ_ADD: on frame completion set `rd_addr_done`=1; hold state until `ss_n` rises.
- WRITE: on frame completion hold state until `ss_n` rises; `rd_addr_done` unchanged.
- READ_DATA, after `rx_valid`:
  - Wait for `tx_valid`=1; latch `tx_data` into the tx shift register; set `tx_loaded`=1.
  - While `tx_loaded`, each `sclk_fall` drives `miso` with the next bit, MSB first (bit 7 on first fall).
  - After DATA_BITS falls: `miso` holds the last bit, `tx_loaded`=0, `rd_addr_done`=0.
  - Further `sclk` edges are ignored until `ss_n` rises.
- `tx_valid` outside the READ_DATA wait window is ignored; no latch.
- `ss_n` synced high in any non-IDLE state:
  - Next cycle -> IDLE; partial frame discarded, no `rx_valid`.
  - `miso`=0, `tx_loaded`=0.
  - `rd_addr_done` retained, except a partially transmitted read-data frame does not clear it.
- `ss_n` rising in the same `clk` cycle as the detected 10th `sclk_rise`: abort wins, no `rx_valid`.
- `sclk` edges while in IDLE are ignored.
- `rst` mid-frame: immediate return to reset values; `rx_valid` never pulses for that frame.
- Counter saturates at FRAME_BITS; extra rises in WRITE/READ_ADD do not wrap or emit a second `rx_valid`.

Test Plan:
- Reset: hold `rst` 3 cycles with `ss_n`=0 and toggling `sclk` -> `miso`=0, `rx_valid`=0, `rx_data`=0 throughout.
- Write address: `ss_n` low, shift 10'b00_0101_0101 -> single `rx_valid` pulse, `rx_data`=0x055; then `ss_n` high -> IDLE.
- Write data: frame 10'b01_1010_1010 -> `rx_data`=0x1AA, one pulse; `rd_addr_done` stays 0.
- Read sequence:
  - Frame 10'b10_0000_0111 -> `rx_data`=0x207, `rd_addr_done`=1.
  - Next frame 10'b11_0000_0000 -> `rx_data`=0x300.
  - Bench drives `tx_valid` with `tx_data`=0xC3 one cycle later -> `miso` emits 1,1,0,0,0,0,1,1 on 8 successive falls; `rd_addr_done`=0.
- Abort: `ss_n` high after 6 bits of 10'b00_1111_0000 -> no `rx_valid`; next full frame 0x0F0 decodes correctly.
- Stray `tx_valid`=1, `tx_data`=0xFF during a WRITE frame -> no MISO activity, `miso` stays 0.
